// File: rtl/fp32_tx_scheduler.sv
// Round-robin share of one byte-wide UART TX among NUM_REQ FP32 word sources; frames are [tag] + 4 bytes LSB-first.
// Latency: grant edge to first byte_valid_o is 1 cycle; frame = 1 + (TAG_EN+4) + 1 cycles with byte_ready_i high.
// Backpressure: byte_ready_i low stalls the frame with byte_valid_o/byte_data_o held; new words are only accepted in IDLE.
module fp32_tx_scheduler #(
  parameter int         NUM_REQ  = 4,
  parameter bit         TAG_EN   = 1'b1,
  parameter logic [7:0] TAG_BASE = 8'hA0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [32*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  byte_valid_o,
  output logic [7:0]            byte_data_o,
  input  logic                  byte_ready_i,
  output logic                  busy_o,
  output logic [2:0]            grant_id_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ptr_q;
  logic [2:0]  grant_id_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;

  logic        gnt_hit;
  logic [2:0]  gnt_idx;
  logic [31:0] gnt_word;
  logic        xfer;
  logic        grant_now;

  // Round-robin search: requesters above the pointer beat those at or below it; lowest index wins within each range.
  always_comb begin
    gnt_hit  = 1'b0;
    gnt_idx  = 3'd0;
    gnt_word = 32'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && (3'(k) <= ptr_q)) begin
        gnt_hit  = 1'b1;
        gnt_idx  = 3'(k);
        gnt_word = req_data_i[32*k +: 32];
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && (3'(k) > ptr_q)) begin
        gnt_hit  = 1'b1;
        gnt_idx  = 3'(k);
        gnt_word = req_data_i[32*k +: 32];
      end
    end
  end

  assign grant_now = (state_q == S_IDLE) && gnt_hit;

  // One-hot accept strobe, only while idle and only toward the chosen valid requester.
  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = grant_now && (gnt_idx == 3'(k));
    end
  end

  // Next-state and byte-side outputs; valid is a pure function of state so it cannot be withdrawn before transfer.
  always_comb begin
    state_d      = state_q;
    byte_valid_o = 1'b0;
    byte_data_o  = 8'h00;
    busy_o       = 1'b1;
    xfer         = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (gnt_hit) begin
          state_d = TAG_EN ? S_TAG : S_DATA;
        end
      end
      S_TAG: begin
        byte_valid_o = 1'b1;
        byte_data_o  = TAG_BASE | {5'd0, grant_id_q};
        xfer         = byte_ready_i;
        if (xfer) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        byte_valid_o = 1'b1;
        case (byte_idx_q)
          2'd0:    byte_data_o = word_q[7:0];
          2'd1:    byte_data_o = word_q[15:8];
          2'd2:    byte_data_o = word_q[23:16];
          default: byte_data_o = word_q[31:24];
        endcase
        xfer = byte_ready_i;
        if (xfer && (byte_idx_q == 2'd3)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register plus grant-time capture of word, id and pointer; reset drops any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= 3'(NUM_REQ - 1);
      grant_id_q <= 3'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        word_q     <= gnt_word;
        grant_id_q <= gnt_idx;
        ptr_q      <= gnt_idx;
        byte_idx_q <= 2'd0;
      end else if ((state_q == S_DATA) && xfer) begin
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

  assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_fp32_tx_scheduler.sv
// Directed bench for fp32_tx_scheduler: per-cycle vector table on a tagged instance, plus a hand sequence on an untagged one.
// Inputs change on the falling edge; outputs are compared 1 time unit later, well before the next rising edge.
module tb_fp32_tx_scheduler;

  logic         clk;
  logic         rst;

  logic [3:0]   vld;
  logic [127:0] dat;
  logic [3:0]   rr;
  logic         bv;
  logic [7:0]   bd;
  logic         rdy;
  logic         busy;
  logic [2:0]   gid;

  logic [3:0]   vld0;
  logic [127:0] dat0;
  logic [3:0]   rr0;
  logic         bv0;
  logic [7:0]   bd0;
  logic         rdy0;
  logic         busy0;
  logic [2:0]   gid0;

  fp32_tx_scheduler #(.NUM_REQ(4), .TAG_EN(1'b1), .TAG_BASE(8'hA0)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(vld), .req_data_i(dat), .req_ready_o(rr),
    .byte_valid_o(bv), .byte_data_o(bd), .byte_ready_i(rdy), .busy_o(busy), .grant_id_o(gid)
  );

  fp32_tx_scheduler #(.NUM_REQ(4), .TAG_EN(1'b0), .TAG_BASE(8'hA0)) u_dut_notag (
    .clk_i(clk), .rst_i(rst), .req_valid_i(vld0), .req_data_i(dat0), .req_ready_o(rr0),
    .byte_valid_o(bv0), .byte_data_o(bd0), .byte_ready_i(rdy0), .busy_o(busy0), .grant_id_o(gid0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    bit           chk;
    logic         rst;
    logic [3:0]   vld;
    logic         rdy;
    logic [127:0] dat;
    logic [3:0]   rr;
    logic         bv;
    logic [7:0]   bd;
    logic         busy;
    logic [2:0]   gid;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] tbl_dat;
  int           n_vec;
  int           n_bad;

  task automatic add(input string n, input bit c, input logic r, input logic [3:0] v, input logic y,
                     input logic [3:0] e_rr, input logic e_bv, input logic [7:0] e_bd,
                     input logic e_busy, input logic [2:0] e_gid);
    vec_t t;
    t.name = n; t.chk = c; t.rst = r; t.vld = v; t.rdy = y; t.dat = tbl_dat;
    t.rr = e_rr; t.bv = e_bv; t.bd = e_bd; t.busy = e_busy; t.gid = e_gid;
    vecs.push_back(t);
  endtask

  task automatic add_reset(input string n);
    add(n, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd0);
  endtask

  // Grant cycle, tag, four data bytes LSB-first, one DONE cycle; byte_ready held high.
  task automatic add_frame(input string n, input int k, input logic [31:0] w, input logic [3:0] v_gnt,
                           input logic [3:0] v_rest, input logic [2:0] prev_gid);
    logic [3:0] one;
    logic [7:0] tag;
    one = 4'b0001;
    tag = 8'hA0 | 8'(k);
    add({n, "_grant"}, 1'b1, 1'b0, v_gnt, 1'b1, one << k, 1'b0, 8'h00, 1'b0, prev_gid);
    add({n, "_tag"}, 1'b1, 1'b0, v_rest, 1'b1, 4'b0000, 1'b1, tag, 1'b1, 3'(k));
    for (int b = 0; b < 4; b++) begin
      add($sformatf("%s_byte%0d", n, b), 1'b1, 1'b0, v_rest, 1'b1, 4'b0000, 1'b1, w[8*b +: 8], 1'b1, 3'(k));
    end
    add({n, "_done"}, 1'b1, 1'b0, v_rest, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 3'(k));
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  initial begin
    logic [16:0] got_v;
    logic [16:0] exp_v;
    logic [31:0] w0;

    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; vld = '0; dat = '0; rdy = 1'b0;
    vld0 = '0; dat0 = '0; rdy0 = 1'b0;

    // Single tagged frame from requester 2.
    tbl_dat = {32'h0, 32'h44434241, 64'h0};
    add_reset("rst_a");
    add("reset_state", 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd0);
    add_frame("req2", 2, 32'h44434241, 4'b0100, 4'b0000, 3'd0);
    add("req2_idle", 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd2);

    // All requesters valid: rotation 0,1,2,3,0.
    add_reset("rst_b");
    tbl_dat = {32'h33323133, 32'h33323132, 32'h33323131, 32'h33323130};
    for (int f = 0; f < 5; f++) begin
      add_frame($sformatf("rr_f%0d", f), f % 4, 32'h33323130 + 32'(f % 4), 4'b1111, 4'b1111,
                (f == 0) ? 3'd0 : 3'((f - 1) % 4));
    end
    add("rr_idle", 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd0);

    // Output stall in DATA with ready pattern 1-0-0-1.
    add_reset("rst_c");
    tbl_dat = {32'h0, 32'h44434241, 64'h0};
    add("st_grant", 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 3'd0);
    add("st_tag",   1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA2, 1'b1, 3'd2);
    add("st_41",    1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h41, 1'b1, 3'd2);
    add("st_42a",   1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h42, 1'b1, 3'd2);
    add("st_42b",   1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h42, 1'b1, 3'd2);
    add("st_42c",   1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h42, 1'b1, 3'd2);
    add("st_43",    1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h43, 1'b1, 3'd2);
    add("st_44",    1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h44, 1'b1, 3'd2);
    add("st_done",  1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 3'd2);
    add("st_idle",  1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd2);

    // Pointer at 3 after reset: req1 beats req3, then req3 gets the next frame.
    add_reset("rst_d");
    tbl_dat = {32'h3B3A3938, 32'h0, 32'h1B1A1918, 32'h0};
    add_frame("wrap1", 1, 32'h1B1A1918, 4'b1010, 4'b1010, 3'd0);
    add_frame("wrap3", 3, 32'h3B3A3938, 4'b1010, 4'b1010, 3'd1);
    add("wrap_idle", 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd3);

    // Reset while byte index 2 is on the line, then req0 frame restarts from its tag.
    add_reset("rst_e");
    tbl_dat = {32'h0, 32'h44434241, 32'h0, 32'h04030201};
    add("ab_grant", 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 3'd0);
    add("ab_tag",   1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA2, 1'b1, 3'd2);
    add("ab_41",    1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h41, 1'b1, 3'd2);
    add("ab_42",    1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h42, 1'b1, 3'd2);
    add("ab_43rst", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h43, 1'b1, 3'd2);
    add("ab_post",  1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd0);
    add_frame("ab_req0", 0, 32'h04030201, 4'b0001, 4'b0000, 3'd0);
    add("ab_idle",  1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      vld = vecs[i].vld;
      rdy = vecs[i].rdy;
      dat = vecs[i].dat;
      #1;
      if (vecs[i].chk) begin
        got_v = {rr, bv, bd, busy, gid};
        exp_v = {vecs[i].rr, vecs[i].bv, vecs[i].bd, vecs[i].busy, vecs[i].gid};
        n_vec++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL %s: got rr=%b bv=%b bd=%h busy=%b gid=%0d, expected rr=%b bv=%b bd=%h busy=%b gid=%0d",
                   vecs[i].name, rr, bv, bd, busy, gid,
                   vecs[i].rr, vecs[i].bv, vecs[i].bd, vecs[i].busy, vecs[i].gid);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0; vld = '0; rdy = 1'b0;

    // Untagged instance: req1 word DEADBEEF goes out as EF BE AD DE, first byte one cycle after the accept.
    w0 = 32'hDEADBEEF;
    vld0 = 4'b0010;
    dat0 = {64'h0, 32'hDEADBEEF, 32'h0};
    rdy0 = 1'b1;
    #1;
    chk("notag_grant_ready", {28'h0, rr0}, 32'h2);
    chk("notag_grant_valid", {31'h0, bv0}, 32'h0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      vld0 = 4'b0000;
      #1;
      chk($sformatf("notag_byte%0d", b), {22'h0, bv0, busy0, bd0}, {22'h0, 1'b1, 1'b1, w0[8*b +: 8]});
    end
    chk("notag_gid", {29'h0, gid0}, 32'd1);
    @(negedge clk);
    #1;
    chk("notag_done", {30'h0, bv0, busy0}, 32'h1);
    @(negedge clk);
    #1;
    chk("notag_idle", {30'h0, bv0, busy0}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
